// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the cpu MEM-stage port, the debug/loader port and the data-memory port.
// slave = arbiter view, master = requester/memory-model view.
interface dmem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port fixed-latency data memory between the cpu MEM stage and a
// debug/loader port; cpu has priority, a starvation counter guarantees dbg progress.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  dmem_port_arbiter_if.slave  bus
);

  localparam int unsigned LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t              state;
  logic [LAT_W-1:0]    lat_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                owner_dbg;

  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   dbg_rdata_q;
  logic                cpu_done_q;
  logic                dbg_ack_q;

  logic                dbg_win;
  req_t                cpu_pkt;
  req_t                dbg_pkt;
  req_t                grant_pkt;

  // dbg wins only when cpu is absent or dbg has been starved long enough
  always_comb begin
    dbg_win   = bus.dbg_req & (~bus.cpu_req | (starve_cnt == STARVE_MAX));
    cpu_pkt   = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
    dbg_pkt   = '{we: bus.dbg_we, addr: bus.dbg_addr, wdata: bus.dbg_wdata};
    grant_pkt = dbg_win ? dbg_pkt : cpu_pkt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      owner_dbg   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      dbg_ack_q   <= 1'b0;
    end else begin
      mem_en_q   <= 1'b0;
      cpu_done_q <= 1'b0;
      dbg_ack_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!bus.dbg_req) starve_cnt <= '0;
          if (bus.cpu_req || bus.dbg_req) begin
            state       <= ACCESS;
            owner_dbg   <= dbg_win;
            lat_cnt     <= '0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= grant_pkt.we;
            mem_addr_q  <= grant_pkt.addr;
            mem_wdata_q <= grant_pkt.wdata;
            if (dbg_win) begin
              starve_cnt <= '0;
            end else if (bus.dbg_req && (starve_cnt != STARVE_MAX)) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
          end
        end
        ACCESS: begin
          // read data is captured for writes too; the requester ignores it
          if (lat_cnt == LAT_LAST) begin
            state <= DONE;
            if (owner_dbg) begin
              dbg_ack_q   <= 1'b1;
              dbg_rdata_q <= bus.mem_rdata;
            end else begin
              cpu_done_q  <= 1'b1;
              cpu_rdata_q <= bus.mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        DONE: begin
          // no re-grant here: cpu_req is still high while the pipeline advances
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_done_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each attached to a small word memory model.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(4)) u1 (
    .clk(clk), .reset(reset), .bus(if1.slave));
  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_LIMIT(4)) u3 (
    .clk(clk), .reset(reset), .bus(if3.slave));

  // memory models: data valid in the MEM_LAT-th cycle counting the mem_en cycle
  logic [31:0] mem1 [16];
  logic [31:0] mem3 [16];
  logic [31:0] p1, p2;

  assign if1.mem_rdata = if1.mem_en ? mem1[if1.mem_addr[5:2]] : 32'hDEAD_BEEF;
  always @(posedge clk)
    if (if1.mem_en && if1.mem_we) mem1[if1.mem_addr[5:2]] <= if1.mem_wdata;

  always @(posedge clk) begin
    p1 <= if3.mem_en ? mem3[if3.mem_addr[5:2]] : 32'hDEAD_BEEF;
    p2 <= p1;
    if (if3.mem_en && if3.mem_we) mem3[if3.mem_addr[5:2]] <= if3.mem_wdata;
  end
  assign if3.mem_rdata = p2;

  int en_cnt1 = 0;
  int ack_cnt1 = 0;
  always @(posedge clk) begin
    if (if1.mem_en)  en_cnt1  <= en_cnt1 + 1;
    if (if1.dbg_ack) ack_cnt1 <= ack_cnt1 + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // one cpu access on the MEM_LAT=1 instance; lat = cycles from request to stall low
  task automatic cpu_access1(input logic we, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd, output int lat);
    if1.cpu_req = 1'b1; if1.cpu_we = we; if1.cpu_addr = a; if1.cpu_wdata = d;
    lat = 0; rd = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!if1.cpu_stall) begin
        rd = if1.cpu_rdata;
        break;
      end
      lat++;
      cyc();
    end
    cyc();
    if1.cpu_req = 1'b0;
  endtask

  logic [31:0] rd, rd2;
  int lat, cpu_lat, dbg_lat, en0, ack0;
  int ncpu, ndbg, ng;
  logic [31:0] gaddr [8];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 32'h100 + 32'(i);
      mem3[i] = '0;
    end
    mem1[3] = 32'h2A;
    mem1[15] = 32'h10F;
    reset = 1'b1;
    if1.cpu_req = 0; if1.cpu_we = 0; if1.cpu_addr = 0; if1.cpu_wdata = 0;
    if1.dbg_req = 0; if1.dbg_we = 0; if1.dbg_addr = 0; if1.dbg_wdata = 0;
    if3.cpu_req = 0; if3.cpu_we = 0; if3.cpu_addr = 0; if3.cpu_wdata = 0;
    if3.dbg_req = 0; if3.dbg_we = 0; if3.dbg_addr = 0; if3.dbg_wdata = 0;

    // reset state
    cyc(); cyc();
    @(negedge clk);
    check("rst_mem_en", 32'(if1.mem_en), 0);
    check("rst_dbg_ack", 32'(if1.dbg_ack), 0);
    check("rst_cpu_rdata", if1.cpu_rdata, 0);
    check("rst_stall_idle", 32'(if1.cpu_stall), 0);
    if1.cpu_req = 1'b1;
    #1;
    check("rst_stall_follows_req", 32'(if1.cpu_stall), 1);
    if1.cpu_req = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();

    // 1: cpu load, MEM_LAT=1
    en0 = en_cnt1;
    cpu_access1(1'b0, 32'h0C, 32'h0, rd, lat);
    check("t1_lat", 32'(lat), 2);
    check("t1_rdata", rd, 32'h2A);
    check("t1_one_strobe", 32'(en_cnt1 - en0), 1);

    // 2: simultaneous dbg write and cpu load; cpu first
    if1.cpu_req = 1'b1; if1.cpu_we = 1'b0; if1.cpu_addr = 32'h04;
    if1.dbg_req = 1'b1; if1.dbg_we = 1'b1; if1.dbg_addr = 32'h00; if1.dbg_wdata = 32'h55;
    cpu_lat = -1; dbg_lat = -1;
    for (int i = 0; i < 20 && dbg_lat < 0; i++) begin
      @(negedge clk);
      if (cpu_lat < 0 && !if1.cpu_stall) begin cpu_lat = i; rd = if1.cpu_rdata; end
      if (if1.dbg_ack) dbg_lat = i;
      cyc();
      if (cpu_lat >= 0) if1.cpu_req = 1'b0;
    end
    if1.dbg_req = 1'b0; if1.dbg_we = 1'b0;
    check("t2_cpu_lat", 32'(cpu_lat), 2);
    check("t2_cpu_rdata", rd, 32'h101);
    check("t2_dbg_lat", 32'(dbg_lat), 5);
    check("t2_mem_written", mem1[0], 32'h55);
    cpu_access1(1'b0, 32'h00, 32'h0, rd, lat);
    check("t2_readback", rd, 32'h55);

    // 3: back-to-back cpu loads with dbg held -> 5th grant is dbg
    if1.dbg_we = 1'b0; if1.dbg_addr = 32'h3C; if1.dbg_req = 1'b1; if1.cpu_we = 1'b0;
    ncpu = 0; ndbg = 0; ng = 0;
    for (int i = 0; i < 80 && !(ncpu == 6 && ndbg == 1); i++) begin
      if1.cpu_req = (ncpu < 6);
      if1.cpu_addr = 32'h10 + 32'(ncpu) * 4;
      @(negedge clk);
      if (if1.mem_en && ng < 8) begin gaddr[ng] = if1.mem_addr; ng++; end
      if (if1.mem_en && if1.mem_addr == 32'h3C)
        check("t3_starve_clr", 32'(u1.starve_cnt), 0);
      if (if1.cpu_req && !if1.cpu_stall) begin
        check($sformatf("t3_cpu_rd%0d", ncpu), if1.cpu_rdata, 32'h104 + 32'(ncpu));
        ncpu++;
      end
      if (if1.dbg_ack) begin
        check("t3_dbg_rd", if1.dbg_rdata, 32'h10F);
        ndbg++;
        if1.dbg_req = 1'b0;
      end
      cyc();
    end
    if1.cpu_req = 1'b0;
    check("t3_ncpu", 32'(ncpu), 6);
    check("t3_ndbg", 32'(ndbg), 1);
    check("t3_grants", 32'(ng), 7);
    check("t3_g1", gaddr[0], 32'h10);
    check("t3_g4", gaddr[3], 32'h1C);
    check("t3_g5_dbg", gaddr[4], 32'h3C);
    check("t3_g6", gaddr[5], 32'h20);
    check("t3_g7", gaddr[6], 32'h24);

    // 6: dbg drops req after grant; inputs changed after grant are ignored
    en0 = en_cnt1; ack0 = ack_cnt1;
    if1.dbg_req = 1'b1; if1.dbg_we = 1'b0; if1.dbg_addr = 32'h0C;
    cyc();
    if1.dbg_req = 1'b0; if1.dbg_addr = 32'h00;
    for (int i = 0; i < 8; i++) cyc();
    check("t6_one_ack", 32'(ack_cnt1 - ack0), 1);
    check("t6_one_strobe", 32'(en_cnt1 - en0), 1);
    check("t6_rdata_held", if1.dbg_rdata, 32'h2A);
    check("t6_idle", 32'(u1.state), 0);

    // 5: reset during a dbg read's ACCESS cycle
    ack0 = ack_cnt1;
    if1.dbg_req = 1'b1; if1.dbg_addr = 32'h04;
    cyc();
    if1.dbg_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t5_in_access", 32'(if1.mem_en), 1);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("t5_no_ack", 32'(if1.dbg_ack), 0);
    check("t5_mem_en0", 32'(if1.mem_en), 0);
    check("t5_dbg_rdata0", if1.dbg_rdata, 0);
    check("t5_cpu_rdata0", if1.cpu_rdata, 0);
    for (int i = 0; i < 4; i++) cyc();
    check("t5_ack_never", 32'(ack_cnt1 - ack0), 0);
    cpu_access1(1'b0, 32'h0C, 32'h0, rd, lat);
    check("t5_cpu_lat", 32'(lat), 2);
    check("t5_cpu_rdata", rd, 32'h2A);

    // 4: MEM_LAT=3 store by cpu, readback via dbg
    if3.cpu_req = 1'b1; if3.cpu_we = 1'b1; if3.cpu_addr = 32'h08; if3.cpu_wdata = 32'h7;
    cpu_lat = -1;
    for (int i = 0; i < 20 && cpu_lat < 0; i++) begin
      @(negedge clk);
      if (!if3.cpu_stall) cpu_lat = i;
      cyc();
    end
    if3.cpu_req = 1'b0; if3.cpu_we = 1'b0;
    check("t4_store_lat", 32'(cpu_lat), 4);
    check("t4_mem_written", mem3[2], 32'h7);
    if3.dbg_req = 1'b1; if3.dbg_we = 1'b0; if3.dbg_addr = 32'h08;
    dbg_lat = -1; rd2 = '0;
    for (int i = 0; i < 20 && dbg_lat < 0; i++) begin
      @(negedge clk);
      if (if3.dbg_ack) begin dbg_lat = i; rd2 = if3.dbg_rdata; end
      cyc();
      if (i == 0) if3.dbg_req = 1'b0;
    end
    check("t4_dbg_lat", 32'(dbg_lat), 4);
    check("t4_dbg_rdata", rd2, 32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
